// File: rtl/conf_int_add_pkg.sv
// Shared geometry, level/truncation types and helpers for the multi-level approximate adder.
package conf_int_add_pkg;

   localparam int unsigned DATA_PATH_BITWIDTH = 16;
   localparam int unsigned APX_STEP           = 4;
   localparam int unsigned NUM_LVLS           = 4;
   localparam int unsigned LW        = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
   localparam int unsigned MAX_TRUNC = (NUM_LVLS - 1) * APX_STEP;
   localparam int unsigned TW        = (MAX_TRUNC > 0) ? $clog2(MAX_TRUNC + 1) : 1;

   typedef logic [LW-1:0] lvl_t;
   typedef logic [TW-1:0] trunc_t;

   typedef struct packed {
      logic [DATA_PATH_BITWIDTH-1:0] a;
      logic [DATA_PATH_BITWIDTH-1:0] b;
      lvl_t                          lvl;
   } beat_t;

   function automatic trunc_t lvl2trunc(lvl_t lvl);
      return TW'(32'(lvl) * APX_STEP);
   endfunction

   // Accurate select overrides the request; out-of-range requests saturate to the top level.
   function automatic lvl_t clamp_lvl(lvl_t apx_lvl, logic acc__sel);
      if (acc__sel)
         return '0;
      if (32'(apx_lvl) > NUM_LVLS - 1)
         return LW'(NUM_LVLS - 1);
      return apx_lvl;
   endfunction

   function automatic logic [DATA_PATH_BITWIDTH-1:0] mask_lsb(logic [DATA_PATH_BITWIDTH-1:0] x,
                                                              trunc_t t);
      return x & ~((DATA_PATH_BITWIDTH'(1) << t) - DATA_PATH_BITWIDTH'(1));
   endfunction

endpackage

// File: rtl/conf_int_add__pipe__apx_core.sv
// Combinational masked adder: drops trunc LSBs of both operands, extends, adds into W+1 bits.
module conf_int_add__pipe__apx_core #(
   parameter int unsigned W           = 16,
   parameter int unsigned SIGNED_MODE = 1,
   parameter int unsigned TW          = 4
) (
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [TW-1:0] trunc,
   output logic [W:0]    sum
);

   logic [W-1:0] mask;
   logic [W-1:0] am;
   logic [W-1:0] bm;
   logic         a_ext;
   logic         b_ext;

   assign mask  = ~((W'(1) << trunc) - W'(1));
   assign am    = a & mask;
   assign bm    = b & mask;
   assign a_ext = (SIGNED_MODE != 0) ? am[W-1] : 1'b0;
   assign b_ext = (SIGNED_MODE != 0) ? bm[W-1] : 1'b0;
   assign sum   = {a_ext, am} + {b_ext, bm};

endmodule

// File: rtl/conf_int_add__pipe__multi_lvl.sv
// Two-stage valid/ready pipelined adder with per-beat accuracy level and saturating approx counter.
module conf_int_add__pipe__multi_lvl
   import conf_int_add_pkg::*;
#(
   parameter int unsigned SIGNED_MODE  = 1,
   parameter int unsigned CNT_BITWIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   input  logic [LW-1:0]                 apx_lvl,
   input  logic                          acc__sel,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH:0]   d,
   output logic [LW-1:0]                 d_lvl,
   input  logic                          cnt_clr,
   output logic [CNT_BITWIDTH-1:0]       apx_cnt
);

   localparam int unsigned W = DATA_PATH_BITWIDTH;

   logic   run_q;
   logic   s1_v;
   beat_t  s1_q;
   logic   s1_adv;
   logic   s2_adv;
   logic   in_fire;
   logic   out_fire;
   lvl_t   in_lvl;
   trunc_t in_trunc;
   trunc_t s1_trunc;
   logic [W:0] sum_c;

   // Handshake: a stage moves when it is empty or its successor moves.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_v || s2_adv;
   assign in_ready = run_q && s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   assign in_lvl   = clamp_lvl(apx_lvl, acc__sel);
   assign in_trunc = lvl2trunc(in_lvl);
   assign s1_trunc = lvl2trunc(s1_q.lvl);

   // Holds in_ready low while in reset and for the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v <= 1'b0;
         s1_q <= '0;
      end else if (s1_adv) begin
         s1_v <= in_fire;
         if (in_fire) begin
            s1_q.a   <= mask_lsb(a, in_trunc);
            s1_q.b   <= mask_lsb(b, in_trunc);
            s1_q.lvl <= in_lvl;
         end
      end
   end

   conf_int_add__pipe__apx_core #(
      .W          (W),
      .SIGNED_MODE(SIGNED_MODE),
      .TW         (TW)
   ) u_core (
      .a    (s1_q.a),
      .b    (s1_q.b),
      .trunc(s1_trunc),
      .sum  (sum_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         d         <= '0;
         d_lvl     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_v;
         if (s1_v) begin
            d     <= sum_c;
            d_lvl <= s1_q.lvl;
         end
      end
   end

   // Clear takes priority over a same-cycle approximate delivery.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         apx_cnt <= '0;
      else if (cnt_clr)
         apx_cnt <= '0;
      else if (out_fire && (d_lvl != '0) && (apx_cnt != '1))
         apx_cnt <= apx_cnt + CNT_BITWIDTH'(1);
   end

endmodule

// File: tb/tb_conf_int_add__pipe__multi_lvl.sv
// Randomised and directed bench for the multi-level pipelined adder against a queue-based model.
module tb_conf_int_add__pipe__multi_lvl;
   import conf_int_add_pkg::*;

   localparam int unsigned W    = DATA_PATH_BITWIDTH;
   localparam int          CMAX = 65535;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [LW-1:0] apx_lvl = '0;
   logic          acc__sel = 1'b0;
   logic          out_ready = 1'b0;
   logic          cnt_clr = 1'b0;

   logic          in_ready_s, out_valid_s, in_ready_u, out_valid_u;
   logic [W:0]    d_s, d_u;
   logic [LW-1:0] d_lvl_s, d_lvl_u;
   logic [15:0]   apx_cnt_s, apx_cnt_u;

   always #5 clk = ~clk;

   conf_int_add__pipe__multi_lvl #(.SIGNED_MODE(1), .CNT_BITWIDTH(16)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
      .apx_lvl(apx_lvl), .acc__sel(acc__sel), .out_valid(out_valid_s), .out_ready(out_ready),
      .d(d_s), .d_lvl(d_lvl_s), .cnt_clr(cnt_clr), .apx_cnt(apx_cnt_s));

   conf_int_add__pipe__multi_lvl #(.SIGNED_MODE(0), .CNT_BITWIDTH(16)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .a(a), .b(b),
      .apx_lvl(apx_lvl), .acc__sel(acc__sel), .out_valid(out_valid_u), .out_ready(out_ready),
      .d(d_u), .d_lvl(d_lvl_u), .cnt_clr(cnt_clr), .apx_cnt(apx_cnt_u));

   typedef struct {
      logic [W:0] ds;
      logic [W:0] du;
      int         lvl;
      longint     t;
   } exp_t;

   exp_t   q[$];
   int     m_cnt = 0;
   longint edge_n = 0;
   bit     ready_en = 1'b0;
   int     n_in = 0;
   int     n_out = 0;
   int     pass_cnt = 0;
   int     chk_cnt = 0;

   task automatic check(string nm, longint got, longint exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, got, exp, $time);
   endtask

   // Sum of the operands with the low L*APX_STEP bits floored away, in W+1 bits.
   function automatic logic [W:0] model_d(logic [W-1:0] x, logic [W-1:0] y, int l, bit sgn);
      longint vx, vy;
      int     t;
      t  = l * APX_STEP;
      vx = sgn ? longint'($signed(x)) : longint'(x);
      vy = sgn ? longint'($signed(y)) : longint'(y);
      vx = (vx >>> t) * (longint'(1) << t);
      vy = (vy >>> t) * (longint'(1) << t);
      return (W+1)'(vx + vy);
   endfunction

   function automatic int eff_lvl(int req, bit acc);
      if (acc) return 0;
      return (req > NUM_LVLS - 1) ? NUM_LVLS - 1 : req;
   endfunction

   function automatic bit exp_valid();
      return (q.size() > 0) && (q[0].t + 1 < edge_n);
   endfunction

   function automatic bit exp_ready();
      return ready_en && ((q.size() < 2) || out_ready);
   endfunction

   // Model: a two-deep ordered buffer; each beat becomes visible the edge after its accept.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_cnt    = 0;
         ready_en = 1'b0;
         edge_n   = 0;
      end else begin
         bit ev, er;
         ev = exp_valid();
         er = exp_ready();
         if (ev && out_ready) begin
            if (q[0].lvl != 0 && m_cnt != CMAX) m_cnt++;
            void'(q.pop_front());
            n_out++;
         end
         if (cnt_clr) m_cnt = 0;
         if (er && in_valid) begin
            int l;
            l = eff_lvl(int'(apx_lvl), acc__sel);
            q.push_back('{ds: model_d(a, b, l, 1'b1), du: model_d(a, b, l, 1'b0), lvl: l, t: edge_n});
            n_in++;
         end
         edge_n++;
         ready_en = 1'b1;
      end
   end

   bit         pv = 1'b0;
   bit         pr = 1'b0;
   logic [W:0] pd = '0;

   always @(negedge clk) begin
      if (!rst) begin
         pv = 1'b0;
      end else begin
         bit ev;
         ev = exp_valid();
         check("out_valid", longint'(out_valid_s), longint'(ev));
         check("out_valid_u", longint'(out_valid_u), longint'(ev));
         check("in_ready", longint'(in_ready_s), longint'(exp_ready()));
         check("in_ready_u", longint'(in_ready_u), longint'(exp_ready()));
         check("apx_cnt", longint'(apx_cnt_s), longint'(m_cnt));
         check("apx_cnt_u", longint'(apx_cnt_u), longint'(m_cnt));
         if (ev) begin
            check("d", longint'(d_s), longint'(q[0].ds));
            check("d_lvl", longint'(d_lvl_s), longint'(q[0].lvl));
            check("d_u", longint'(d_u), longint'(q[0].du));
            check("d_lvl_u", longint'(d_lvl_u), longint'(q[0].lvl));
         end
         if (pv && !pr && out_valid_s) check("d_hold", longint'(d_s), longint'(pd));
         pv = out_valid_s;
         pr = out_ready;
         pd = d_s;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_beat(logic [W-1:0] x, logic [W-1:0] y, int l, bit acc);
      a        = x;
      b        = y;
      apx_lvl  = LW'(l);
      acc__sel = acc;
   endtask

   task automatic send(logic [W-1:0] x, logic [W-1:0] y, int l, bit acc);
      set_beat(x, y, l, acc);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready_s) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      in_valid = 1'b0;
      check("send_timeout", 0, 1);
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid_s) begin
            lat = i;
            return;
         end
      end
      check("wait_out_timeout", 0, 1);
   endtask

   // Streams n beats with random operands and nonzero levels at full throughput.
   task automatic stream_apx(int n, bit lvl1_only);
      int base;
      base      = n_in;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < n + 100 && (n_in - base) < n; i++) begin
         set_beat(W'($urandom), W'($urandom), lvl1_only ? 1 : int'($urandom_range(1, 3)), 1'b0);
         tick();
      end
      in_valid = 1'b0;
      check("stream_count", longint'(n_in - base), longint'(n));
      repeat (4) tick();
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int acc_n;
      int idx;
      int base;
      logic [W-1:0] ta [4];
      logic [W-1:0] tb_ [4];

      #1;
      check("rst_out_valid", longint'(out_valid_s), 0);
      check("rst_d", longint'(d_s), 0);
      check("rst_d_lvl", longint'(d_lvl_s), 0);
      check("rst_apx_cnt", longint'(apx_cnt_s), 0);
      check("rst_in_ready", longint'(in_ready_s), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      check("pin_lvl0", longint'(model_d(16'h7FFF, 16'h0001, 0, 1'b1)), 64'h08000);
      check("pin_lvl2", longint'(model_d(16'h8000, 16'hFF00, 2, 1'b1)), 64'h17F00);
      check("pin_uns", longint'(model_d(16'hFFFF, 16'h0001, 0, 1'b0)), 64'h10000);

      // Directed: accurate, level 1, level 2, accurate override.
      out_ready = 1'b1;
      send(16'h7FFF, 16'h0001, 0, 1'b0);
      wait_out(lat);
      check("t1_latency", longint'(lat), 2);
      check("t1_d", longint'(d_s), 64'h08000);
      check("t1_d_lvl", longint'(d_lvl_s), 0);
      tick();
      check("t1_apx_cnt", longint'(apx_cnt_s), 0);

      send(16'h1234, 16'h0FFF, 1, 1'b0);
      wait_out(lat);
      check("t2_d", longint'(d_s), 64'h02220);
      check("t2_d_lvl", longint'(d_lvl_s), 1);
      tick();
      check("t2_apx_cnt", longint'(apx_cnt_s), 1);
      send(16'h8000, 16'hFF00, 2, 1'b0);
      wait_out(lat);
      check("t2b_d", longint'(d_s), 64'h17F00);
      tick();
      check("t2b_apx_cnt", longint'(apx_cnt_s), 2);

      send(16'h00FF, 16'h0001, 3, 1'b1);
      wait_out(lat);
      check("t3_d", longint'(d_s), 64'h00100);
      check("t3_d_lvl", longint'(d_lvl_s), 0);
      tick();
      check("t3_apx_cnt", longint'(apx_cnt_s), 2);

      // Random traffic with bubbles, backpressure and occasional clears.
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         set_beat(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
         out_ready = ($urandom_range(0, 2) != 0);
         cnt_clr   = ($urandom_range(0, 49) == 0);
         tick();
      end
      in_valid  = 1'b0;
      cnt_clr   = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();

      // Stall: four beats offered, two buffered, all four delivered in order after release.
      ta  = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
      tb_ = '{16'h0002, 16'h0020, 16'h0200, 16'h2000};
      base      = n_out;
      out_ready = 1'b0;
      idx       = 0;
      acc_n     = 0;
      in_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         set_beat(ta[idx], tb_[idx], 0, 1'b0);
         @(negedge clk);
         lat = int'(in_ready_s);
         tick();
         if (lat != 0) begin
            idx++;
            acc_n++;
         end
      end
      check("t4_accepted", longint'(acc_n), 2);
      check("t4_in_ready", longint'(in_ready_s), 0);
      check("t4_d_held", longint'(d_s), 64'h00003);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         set_beat(ta[idx], tb_[idx], 0, 1'b0);
         @(negedge clk);
         lat = int'(in_ready_s);
         tick();
         if (lat != 0) idx++;
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("t4_delivered", longint'(n_out - base), 4);

      // Counter saturation and clear priority.
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      stream_apx(65534, 1'b0);
      check("t5_cnt_fffe", longint'(apx_cnt_s), 64'hFFFE);
      stream_apx(3, 1'b1);
      check("t5_cnt_sat", longint'(apx_cnt_s), 64'hFFFF);
      out_ready = 1'b0;
      send(16'h0005, 16'h0005, 1, 1'b0);
      tick();
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      tick();
      cnt_clr   = 1'b0;
      check("t5_clr_wins", longint'(apx_cnt_s), 0);

      // Reset with both stages full, then unsigned accurate carry-out.
      send(16'h0003, 16'h0003, 1, 1'b0);
      wait_out(lat);
      tick();
      check("t6_cnt_pre", longint'(apx_cnt_s), 1);
      out_ready = 1'b0;
      acc_n     = 0;
      in_valid  = 1'b1;
      set_beat(16'h0042, 16'h0042, 1, 1'b0);
      for (int c = 0; c < 10 && acc_n < 2; c++) begin
         @(negedge clk);
         lat = int'(in_ready_s);
         tick();
         if (lat != 0) acc_n++;
      end
      in_valid = 1'b0;
      check("t6_filled", longint'(acc_n), 2);
      rst = 1'b0;
      #1;
      check("t6_rst_out_valid", longint'(out_valid_s), 0);
      check("t6_rst_apx_cnt", longint'(apx_cnt_s), 0);
      check("t6_rst_in_ready", longint'(in_ready_s), 0);
      repeat (3) tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("t6_no_out", longint'(out_valid_s), 0);
         tick();
      end
      send(16'hFFFF, 16'h0001, 0, 1'b0);
      wait_out(lat);
      check("t6_d_uns", longint'(d_u), 64'h10000);
      check("t6_d_sgn", longint'(d_s), 64'h00000);
      repeat (4) tick();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
